// File: rtl/hourly_chime_buzzer.sv
// rtl/hourly_chime_buzzer.sv - turns the hourly-alarm code into one tone burst per hour count
module hourly_chime_buzzer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TONE_HZ  = 2000,
  parameter int BEEP_MS  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] alarm_en,
  input  logic       mute,
  output logic       buzzer,
  output logic       beep_active,
  output logic [5:0] beep_count
);

  // Half period of the tone and the length of one burst, both in clk cycles.
  localparam int HALF        = CLK_FREQ / (2 * TONE_HZ);
  localparam int BEEP_CYCLES = CLK_FREQ / 1000 * BEEP_MS;
  localparam int HW          = $clog2(HALF);
  localparam int BW          = $clog2(BEEP_CYCLES);

  // Counters run down to zero, so the reload value is the constant minus one.
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BEEP = 1'b1
  } state_t;

  state_t        r_state;
  logic [5:0]    r_en_q;
  logic [HW-1:0] r_tone_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_phase;
  logic [5:0]    r_count;
  logic          r_buzzer;
  logic          r_beep_active;

  state_t        w_state_next;
  logic [HW-1:0] w_tone_next;
  logic [BW-1:0] w_burst_next;
  logic          w_phase_next;
  logic [5:0]    w_count_base;
  logic [5:0]    w_count_next;
  logic          w_change;
  logic          w_window_start;
  logic          w_trigger;

  // Edge detection on the alarm code: even nonzero values are the beep seconds.
  always_comb begin
    w_change       = (alarm_en != r_en_q);
    w_window_start = w_change && (r_en_q == 6'd0);
    w_trigger      = w_change && (alarm_en != 6'd0) && !alarm_en[0];
  end

  // Next-state, counter, phase and burst-count logic.
  always_comb begin
    w_state_next = r_state;
    w_tone_next  = r_tone_cnt;
    w_burst_next = r_burst_cnt;
    w_phase_next = r_phase;
    w_count_base = w_window_start ? 6'd0 : r_count;
    w_count_next = w_count_base;

    if (w_trigger) begin
      // A trigger starts a fresh burst whether idle or mid-burst.
      w_state_next = S_BEEP;
      w_tone_next  = HALF_LAST;
      w_burst_next = BEEP_LAST;
      w_phase_next = 1'b1;
      w_count_next = (w_count_base == 6'd63) ? 6'd63 : w_count_base + 6'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_phase_next = 1'b0;
        end
        S_BEEP: begin
          if (r_burst_cnt == '0) begin
            w_state_next = S_IDLE;
            w_phase_next = 1'b0;
          end else begin
            w_burst_next = r_burst_cnt - BW'(1);
            if (r_tone_cnt == '0) begin
              w_phase_next = ~r_phase;
              w_tone_next  = HALF_LAST;
            end else begin
              w_tone_next = r_tone_cnt - HW'(1);
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_phase_next = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers; en_q tracks the input even in reset so release never triggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q        <= alarm_en;
      r_tone_cnt    <= '0;
      r_burst_cnt   <= '0;
      r_phase       <= 1'b0;
      r_count       <= 6'd0;
      r_buzzer      <= 1'b0;
      r_beep_active <= 1'b0;
    end else begin
      r_en_q        <= alarm_en;
      r_tone_cnt    <= w_tone_next;
      r_burst_cnt   <= w_burst_next;
      r_phase       <= w_phase_next;
      r_count       <= w_count_next;
      r_buzzer      <= w_phase_next & ~mute;
      r_beep_active <= (w_state_next == S_BEEP);
    end
  end

  assign buzzer      = r_buzzer;
  assign beep_active = r_beep_active;
  assign beep_count  = r_count;

endmodule

// File: tb/tb_hourly_chime_buzzer.sv
// tb/tb_hourly_chime_buzzer.sv - directed and random checks of the chime buzzer against a timing model
module tb_hourly_chime_buzzer;

  localparam int HALF = 5;
  localparam int BC   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] alarm_en;
  logic       mute;
  logic       buzzer;
  logic       beep_active;
  logic [5:0] beep_count;

  hourly_chime_buzzer #(
    .CLK_FREQ(1000),
    .TONE_HZ (100),
    .BEEP_MS (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_en   (alarm_en),
    .mute       (mute),
    .buzzer     (buzzer),
    .beep_active(beep_active),
    .beep_count (beep_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a burst is fully described by the cycle it last (re)started on.
  int         cyc       = 0;
  logic [5:0] m_en_prev = 6'd0;
  int         m_cnt     = 0;
  int         m_last    = 0;
  bit         m_have    = 1'b0;

  // Per-section observations of the DUT.
  int  act_cycles = 0;
  int  buz_cycles = 0;
  int  rises      = 0;
  bit  prev_act   = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    act_cycles = 0;
    buz_cycles = 0;
    rises      = 0;
  endtask

  task automatic tick(input logic [5:0] a, input logic m, input logic r);
    int  el;
    bit  e_act;
    bit  e_buz;
    alarm_en = a;
    mute     = m;
    rst      = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_en_prev = a;
      m_cnt     = 0;
      m_have    = 1'b0;
    end else begin
      if (a != m_en_prev) begin
        if (m_en_prev == 6'd0) m_cnt = 0;
        if (a != 6'd0 && (a % 2) == 0) begin
          m_have = 1'b1;
          m_last = cyc;
          m_cnt  = (m_cnt < 63) ? m_cnt + 1 : 63;
        end
      end
      m_en_prev = a;
    end
    el    = cyc - m_last;
    e_act = m_have && (el < BC);
    e_buz = e_act && (((el / HALF) % 2) == 0) && !m;
    #1;
    check("beep_active", {7'd0, beep_active}, {7'd0, e_act});
    check("buzzer", {7'd0, buzzer}, {7'd0, e_buz});
    check("beep_count", {2'd0, beep_count}, 8'(m_cnt));
    if (beep_active === 1'b1) act_cycles++;
    if (buzzer === 1'b1) buz_cycles++;
    if (beep_active === 1'b1 && !prev_act) rises++;
    prev_act = (beep_active === 1'b1);
  endtask

  initial begin
    logic [5:0] ra;
    int         hold;
    bit         rm;

    // Reset with the alarm idle.
    repeat (3) tick(6'd0, 1'b0, 1'b1);
    check("reset_buzzer", {7'd0, buzzer}, 8'd0);
    check("reset_active", {7'd0, beep_active}, 8'd0);
    check("reset_count", {2'd0, beep_count}, 8'd0);
    repeat (5) tick(6'd0, 1'b0, 1'b0);

    // Hour 3 chime: three bursts.
    clear_stats();
    for (int v = 1; v <= 7; v++) repeat (100) tick(6'(v), 1'b0, 1'b0);
    repeat (30) tick(6'd0, 1'b0, 1'b0);
    check("hour3_count", {2'd0, beep_count}, 8'd3);
    check("hour3_bursts", 8'(rises), 8'd3);
    check("hour3_active_cycles", 8'(act_cycles), 8'd60);
    check("hour3_buzz_cycles", 8'(buz_cycles), 8'd30);

    // Held even value: one burst only.
    repeat (10) tick(6'd3, 1'b0, 1'b0);
    clear_stats();
    repeat (500) tick(6'd4, 1'b0, 1'b0);
    check("held_bursts", 8'(rises), 8'd1);
    check("held_active_cycles", 8'(act_cycles), 8'd20);
    check("held_count", {2'd0, beep_count}, 8'd1);

    // Retrigger at cycle 10 of a burst.
    repeat (10) tick(6'd0, 1'b0, 1'b0);
    repeat (5) tick(6'd1, 1'b0, 1'b0);
    clear_stats();
    repeat (10) tick(6'd2, 1'b0, 1'b0);
    repeat (40) tick(6'd4, 1'b0, 1'b0);
    check("retrig_active_cycles", 8'(act_cycles), 8'd30);
    check("retrig_rises", 8'(rises), 8'd1);
    check("retrig_count", {2'd0, beep_count}, 8'd2);

    // Mute from cycle 3 of a burst.
    repeat (10) tick(6'd0, 1'b0, 1'b0);
    repeat (5) tick(6'd1, 1'b0, 1'b0);
    clear_stats();
    repeat (3) tick(6'd2, 1'b0, 1'b0);
    repeat (30) tick(6'd2, 1'b1, 1'b0);
    check("mute_active_cycles", 8'(act_cycles), 8'd20);
    check("mute_buzz_cycles", 8'(buz_cycles), 8'd3);
    check("mute_count", {2'd0, beep_count}, 8'd1);

    // Reset mid-burst with the even value held.
    repeat (10) tick(6'd0, 1'b0, 1'b0);
    repeat (5) tick(6'd1, 1'b0, 1'b0);
    repeat (8) tick(6'd4, 1'b0, 1'b0);
    tick(6'd4, 1'b0, 1'b1);
    check("midrst_active", {7'd0, beep_active}, 8'd0);
    check("midrst_buzzer", {7'd0, buzzer}, 8'd0);
    clear_stats();
    repeat (40) tick(6'd4, 1'b0, 1'b0);
    check("midrst_no_burst", 8'(rises), 8'd0);
    repeat (30) tick(6'd6, 1'b0, 1'b0);
    check("midrst_new_burst", 8'(rises), 8'd1);
    check("midrst_count", {2'd0, beep_count}, 8'd1);

    // Saturation of the burst count within one window.
    for (int i = 0; i < 70; i++) begin
      repeat (3) tick(6'd2, 1'b0, 1'b0);
      repeat (3) tick(6'd4, 1'b0, 1'b0);
    end
    check("sat_count", {2'd0, beep_count}, 8'd63);

    // Random alarm codes, mute and occasional reset.
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0:       ra = 6'd0;
        1:       ra = 6'($urandom_range(0, 63));
        default: ra = 6'(2 * $urandom_range(1, 31));
      endcase
      hold = $urandom_range(1, 30);
      for (int c = 0; c < hold; c++) begin
        rm = ($urandom_range(0, 3) == 0);
        tick(ra, rm, ($urandom_range(0, 199) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
